// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin arbiter sharing one registered output channel between two req/ack requesters
module mux_arbiter #(
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req1,
  input  logic [DATA_W-1:0] x1,
  input  logic              last1,
  output logic              ack1,
  input  logic              req2,
  input  logic [DATA_W-1:0] x2,
  input  logic              last2,
  output logic              ack2,
  output logic [DATA_W-1:0] y,
  output logic              y_valid,
  input  logic              y_ready,
  output logic              addr
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT1 = 2'd1;
  localparam logic [1:0] GRANT2 = 2'd2;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
  logic [1:0] state, state_nxt;
  logic [CW-1:0] cnt;
  logic prio;
  logic out_free, xfer1, xfer2, xfer, req_own, req_oth, last_own, at_max, rel, forced;
  assign out_free = !y_valid | y_ready;
  assign ack1     = (state == GRANT1) & out_free;
  assign ack2     = (state == GRANT2) & out_free;
  assign xfer1    = req1 & ack1;
  assign xfer2    = req2 & ack2;
  assign xfer     = xfer1 | xfer2;
  assign req_own  = (state == GRANT2) ? req2 : req1;
  assign req_oth  = (state == GRANT2) ? req1 : req2;
  assign last_own = (state == GRANT2) ? last2 : last1;
  assign at_max   = cnt == CNT_LAST;
  assign rel      = (state != IDLE) & (!req_own | (xfer & (last_own | at_max)));
  assign forced   = xfer & !last_own & at_max;
  // arbitration in IDLE, hand-over or forced re-grant on release
  always_comb begin
    state_nxt = (state == IDLE) ? ((req1 & (!req2 | !prio)) ? GRANT1 : req2 ? GRANT2 : IDLE) :
                rel ? (req_oth ? ((state == GRANT1) ? GRANT2 : GRANT1) : forced ? state : IDLE) :
                state;
  end
  // grant state, beat counter, round-robin pointer and mux select
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
      prio  <= 1'b0;
      addr  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= rel ? '0 : xfer ? cnt + 1'b1 : cnt;
      prio  <= rel ? (state == GRANT1) : prio;
      addr  <= (state_nxt == GRANT1) ? 1'b0 : (state_nxt == GRANT2) ? 1'b1 : addr;
    end
  end
  // output register: load on a transfer, drop valid once consumed
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      y       <= '0;
      y_valid <= 1'b0;
    end else if (xfer) begin
      y       <= xfer2 ? x2 : x1;
      y_valid <= 1'b1;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end
endmodule
